// File: rtl/alu_seq_core.sv
// Purpose: WIDTH-bit sequential ALU with registered result/flags and one-bit-per-cycle shifts/rotates.
// Latency: ALU ops (0-7, F) and zero-amount shifts are valid 1 cycle after accept; a shift by k>0 takes k+1 cycles.
// Backpressure: valid/ready on both sides; DONE holds result/flags until out_ready, in_ready = IDLE | (DONE & out_ready).
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   in_valid/in_ready     input handshake for op/a/b
//   op[3:0], a, b         opcode and operands (b[SW-1:0] is the shift amount)
//   out_valid/out_ready   output handshake for result/flags
//   result, flags         registered result and {R,V,N,Z,C}
module alu_seq_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] CNT_ONE = {{(SW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic r;
    logic v;
    logic n;
    logic z;
    logic c;
  } flags_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  flags_t           flags_q, flags_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [3:0]       sop_q, sop_d;
  logic             rbit_q, rbit_d;

  logic             accept;
  logic             is_shift;
  logic [SW-1:0]    amt;

  // Single-cycle datapath for the op presented at the input.
  logic [WIDTH-1:0] bb;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  flags_t           alu_flags;

  // One step of the multi-cycle shifter.
  logic [WIDTH-1:0] step_w;
  logic             step_out;

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign flags     = flags_q;

  assign accept   = in_valid & in_ready;
  assign is_shift = (op >= 4'h8) && (op <= 4'hE);
  assign amt      = b[SW-1:0];

  // flags_q is the flag set of the op being retired, so ADC/SBC accepted in
  // DONE chain from it directly at full rate.
  always_comb begin
    bb  = b;
    cin = 1'b0;
    case (op)
      4'h1: cin = flags_q.c;
      4'h2: begin bb = ~b; cin = 1'b1;      end
      4'h3: begin bb = ~b; cin = flags_q.c; end
      default: ;
    endcase
    sum = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, cin};
  end

  always_comb begin
    alu_flags = flags_q;
    alu_res   = a;  // shifts by zero pass A through
    case (op)
      4'h0, 4'h1, 4'h2, 4'h3: begin
        alu_res     = sum[WIDTH-1:0];
        alu_flags.c = sum[WIDTH];
        // carry into the MSB recovered from the MSB sum bit
        alu_flags.v = (a[WIDTH-1] ^ bb[WIDTH-1] ^ sum[WIDTH-1]) ^ sum[WIDTH];
      end
      4'h4: alu_res = a & b;
      4'h5: alu_res = a | b;
      4'h6: alu_res = a ^ b;
      4'h7: alu_res = ~a;
      4'hF: alu_res = b;
      default: ;
    endcase
    alu_flags.n = alu_res[WIDTH-1];
    alu_flags.z = (alu_res == '0);
  end

  // RCL/RCR treat rbit_q as the extra bit of a WIDTH+1-bit ring.
  always_comb begin
    step_w   = work_q;
    step_out = rbit_q;
    case (sop_q)
      4'h8: begin step_out = work_q[WIDTH-1]; step_w = {work_q[WIDTH-2:0], 1'b0};           end
      4'h9: begin step_out = work_q[0];       step_w = {1'b0, work_q[WIDTH-1:1]};           end
      4'hA: begin step_out = work_q[0];       step_w = {work_q[WIDTH-1], work_q[WIDTH-1:1]}; end
      4'hB: begin step_out = work_q[WIDTH-1]; step_w = {work_q[WIDTH-2:0], work_q[WIDTH-1]}; end
      4'hC: begin step_out = work_q[0];       step_w = {work_q[0], work_q[WIDTH-1:1]};       end
      4'hD: begin step_out = work_q[WIDTH-1]; step_w = {work_q[WIDTH-2:0], rbit_q};          end
      4'hE: begin step_out = work_q[0];       step_w = {rbit_q, work_q[WIDTH-1:1]};          end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    sop_d    = sop_q;
    rbit_d   = rbit_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (is_shift && (amt != '0)) begin
            state_d = SHIFT;
            work_d  = a;
            cnt_d   = amt;
            sop_d   = op;
            rbit_d  = flags_q.r;
          end else begin
            state_d  = DONE;
            result_d = alu_res;
            flags_d  = alu_flags;
          end
        end else if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        work_d = step_w;
        rbit_d = step_out;
        cnt_d  = cnt_q - CNT_ONE;
        // result/flags stay untouched until the final step so nothing partial is visible
        if (cnt_q == CNT_ONE) begin
          state_d   = DONE;
          result_d  = step_w;
          flags_d.r = step_out;
          flags_d.n = step_w[WIDTH-1];
          flags_d.z = (step_w == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      sop_q    <= '0;
      rbit_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      sop_q    <= sop_d;
      rbit_q   <= rbit_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Purpose: self-checking bench for alu_seq_core (WIDTH=8) with an in-order scoreboard.
// Latency: expectations are pushed at accept and popped when the output handshake completes.
// Backpressure: out_ready is held low in one scenario to check that DONE holds its outputs.
module tb_alu_seq_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] op = 4'h0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] result;
  logic [4:0] flags;

  int tests_run = 0;
  int tests_failed = 0;

  logic [12:0] sb[$];      // {result, flags}
  logic [4:0]  m_flags = 5'b0;
  logic        accepted = 1'b0;
  logic [3:0]  alu_ops [9] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hF};

  alu_seq_core #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  // Reference model; f is {R,V,N,Z,C} and is updated in accept order.
  function automatic logic [7:0] model(input logic [3:0] o, input logic [7:0] xa,
                                       input logic [7:0] xb, inout logic [4:0] f);
    logic [7:0] bb, res;
    logic [8:0] ring;
    logic r, v, c, ci;
    int s, ss;
    r = f[4]; v = f[3]; c = f[0];
    res = xa;
    case (o)
      4'h0, 4'h1, 4'h2, 4'h3: begin
        bb = (o >= 4'h2) ? ~xb : xb;
        ci = (o == 4'h0) ? 1'b0 : (o == 4'h2) ? 1'b1 : f[0];
        s  = int'(xa) + int'(bb) + int'(ci);
        res = s[7:0];
        c  = (s > 255);
        ss = int'($signed(xa)) + int'($signed(bb)) + int'(ci);
        v  = (ss > 127) || (ss < -128);
      end
      4'h4: res = xa & xb;
      4'h5: res = xa | xb;
      4'h6: res = xa ^ xb;
      4'h7: res = ~xa;
      4'hF: res = xb;
      default: begin
        for (int i = 0; i < int'(xb[2:0]); i++) begin
          case (o)
            4'h8: begin r = res[7]; res = res << 1; end
            4'h9: begin r = res[0]; res = res >> 1; end
            4'hA: begin r = res[0]; res = $signed(res) >>> 1; end
            4'hB: begin r = res[7]; res = {res[6:0], res[7]}; end
            4'hC: begin r = res[0]; res = {res[0], res[7:1]}; end
            4'hD: begin ring = {r, res}; ring = {ring[7:0], ring[8]}; r = ring[8]; res = ring[7:0]; end
            default: begin ring = {r, res}; ring = {ring[0], ring[8:1]}; r = ring[8]; res = ring[7:0]; end
          endcase
        end
      end
    endcase
    f = {r, v, res[7], (res == 8'h00), c};
    return res;
  endfunction

  // One clock: at the negedge retire a completed output against the scoreboard
  // and record an accept; returns 1 time unit after the next posedge.
  task automatic step();
    logic [12:0] e;
    logic [7:0]  r;
    @(negedge clk);
    accepted = 1'b0;
    if (!rst) begin
      if (out_valid && out_ready) begin
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_unexpected: got result=%h flags=%b, required no output", result, flags);
        end else begin
          e = sb.pop_front();
          if ({result, flags} !== e) begin
            tests_failed++;
            $display("FAIL sb_compare: got result=%h flags=%b, required result=%h flags=%b",
                     result, flags, e[12:5], e[4:0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        r = model(op, a, b, m_flags);
        sb.push_back({r, m_flags});
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] o, input logic [7:0] xa, input logic [7:0] xb);
    int n = 0;
    op = o; a = xa; b = xb; in_valid = 1'b1;
    do begin step(); n++; end while (!accepted && n < 100);
    in_valid = 1'b0;
    tests_run++;
    if (!accepted) begin
      tests_failed++;
      $display("FAIL send_timeout: op=%h not accepted in %0d cycles, required accept", o, n);
    end
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 200) begin step(); n++; end
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    tests_run += 4;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    if (in_ready !== 1'b1)  begin tests_failed++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    if (result !== 8'h00)   begin tests_failed++; $display("FAIL reset_result: got %h, required 00", result); end
    if (flags !== 5'b0)     begin tests_failed++; $display("FAIL reset_flags: got %b, required 00000", flags); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_add_overflow();
    send(4'h0, 8'h7F, 8'h01);
    tests_run += 2;
    if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL add_latency: out_valid got %b, required 1", out_valid); end
    if ({result, flags} !== {8'h80, 5'b01100}) begin
      tests_failed++; $display("FAIL add_7f_01: got %h/%b, required 80/01100", result, flags);
    end
  endtask

  task automatic test_carry_chain();
    send(4'h0, 8'hFF, 8'h01);
    tests_run++;
    if ({result, flags} !== {8'h00, 5'b00011}) begin
      tests_failed++; $display("FAIL add_ff_01: got %h/%b, required 00/00011", result, flags);
    end
    send(4'h1, 8'h00, 8'h00);
    tests_run++;
    if ({result, flags} !== {8'h01, 5'b00000}) begin
      tests_failed++; $display("FAIL adc_chain: got %h/%b, required 01/00000", result, flags);
    end
  endtask

  task automatic test_borrow_chain();
    send(4'h2, 8'h05, 8'h05);
    tests_run++;
    if ({result, flags} !== {8'h00, 5'b00011}) begin
      tests_failed++; $display("FAIL sub_05_05: got %h/%b, required 00/00011", result, flags);
    end
    send(4'h0, 8'h00, 8'h00);  // clears C so the SBC sees a pending borrow
    send(4'h3, 8'h00, 8'h01);
    tests_run++;
    if ({result, flags} !== {8'hFE, 5'b00100}) begin
      tests_failed++; $display("FAIL sbc_chain: got %h/%b, required FE/00100", result, flags);
    end
  endtask

  task automatic test_shift();
    send(4'hC, 8'h01, 8'h03);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if ({in_ready, out_valid} !== 2'b00) begin
        tests_failed++; $display("FAIL ror_busy_%0d: in_ready/out_valid got %b%b, required 00", i, in_ready, out_valid);
      end
      step();
    end
    tests_run++;
    if ({out_valid, result, flags} !== {1'b1, 8'h20, 5'b00000}) begin
      tests_failed++; $display("FAIL ror_01_3: got v=%b %h/%b, required v=1 20/00000", out_valid, result, flags);
    end
    send(4'hD, 8'h81, 8'h01);
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL rcl_busy: in_ready got %b, required 0", in_ready); end
    step();
    tests_run++;
    if ({out_valid, result, flags} !== {1'b1, 8'h02, 5'b10000}) begin
      tests_failed++; $display("FAIL rcl_81_1: got v=%b %h/%b, required v=1 02/10000", out_valid, result, flags);
    end
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(4'h4, 8'hF0, 8'h3C);
    op = 4'h5; a = 8'h11; b = 8'h22; in_valid = 1'b1;  // must be ignored while stalled
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if ({out_valid, in_ready, result, flags} !== {1'b1, 1'b0, 8'h30, 5'b10000}) begin
        tests_failed++;
        $display("FAIL hold_%0d: got v=%b rdy=%b %h/%b, required v=1 rdy=0 30/10000",
                 i, out_valid, in_ready, result, flags);
      end
      step();
    end
    op = 4'h6; a = 8'h0F; b = 8'hFF;
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL release_in_ready: got %b, required 1", in_ready); end
    step();
    in_valid = 1'b0;
    tests_run++;
    if ({accepted, out_valid, result, flags} !== {1'b1, 1'b1, 8'hF0, 5'b10100}) begin
      tests_failed++;
      $display("FAIL release_accept: got acc=%b v=%b %h/%b, required acc=1 v=1 F0/10100",
               accepted, out_valid, result, flags);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 24; i++) begin
      op = alu_ops[$urandom_range(0, 8)];
      a = 8'($urandom);
      b = 8'($urandom);
      step();
      tests_run++;
      if (!accepted) begin tests_failed++; $display("FAIL b2b_rate_%0d: op not accepted, required 1/cycle", i); end
    end
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_random_mix();
    for (int i = 0; i < 40; i++) begin
      send(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
    end
    drain();
  endtask

  task automatic test_reset_mid_shift();
    int seen = 0;
    send(4'hC, 8'h80, 8'h07);
    step(); step();
    rst = 1'b1;
    step();
    tests_run += 4;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL abort_out_valid: got %b, required 0", out_valid); end
    if (flags !== 5'b0)     begin tests_failed++; $display("FAIL abort_flags: got %b, required 00000", flags); end
    if (in_ready !== 1'b1)  begin tests_failed++; $display("FAIL abort_in_ready: got %b, required 1", in_ready); end
    if (result !== 8'h00)   begin tests_failed++; $display("FAIL abort_result: got %h, required 00", result); end
    rst = 1'b0;
    sb.delete();
    m_flags = 5'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid) seen++;
    end
    tests_run++;
    if (seen != 0) begin tests_failed++; $display("FAIL abort_no_result: out_valid seen %0d cycles, required 0", seen); end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_carry_chain();
    test_borrow_chain();
    test_shift();
    test_backpressure();
    test_back_to_back();
    test_random_mix();
    test_reset_mid_shift();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
